pipe_int_ctrl: RTL and testbench
================================

// Module: pipe_int_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS datapath. Drives every stage enable/flush, inserts load-use bubbles,
//  and accepts one external interrupt at a time.
//  On acceptance: squashes the instruction in ID, saves its PC in EPC, redirects fetch to the handler.
//  ERET in ID returns fetch to EPC. Sits between the hazard/forwarding unit and the datapath stage registers.
// PARAMETERS
//  HANDLER_ADDR  32'h0000_0100  fetch address loaded on interrupt acceptance
//  SYNC_STAGES   2              flops in irq synchronizer (>=2)
//  GUARD_CYCLES  3              cycles after ERET during which no interrupt is accepted (forward progress)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   synchronous active-low reset
//  irq            in   1   async external interrupt request, level; rising edge = new request
//  int_en         in   1   global interrupt enable (status bit)
//  reg_stall      in   1   load-use stall request from hazard unit
//  id_valid       in   1   ID stage holds a real instruction
//  is_branch_exe  in   1   instruction in EXE is branch/jump (ID holds its delay slot)
//  is_eret_id     in   1   instruction in ID decodes as ERET
//  inst_addr_id   in   32  PC of instruction in ID
//  if_en,id_en,exe_en,mem_en,wb_en      out  1 each  stage enables
//  if_rst,id_rst,exe_rst,mem_rst,wb_rst out  1 each  stage flush (active-high, as datapath expects)
//  pc_override    out  1   1-cycle: IF loads pc_override_addr instead of its pc_src choice
//  pc_override_addr out 32 HANDLER_ADDR on accept, epc on ERET
//  epc            out  32  saved return PC
//  in_handler     out  1   interrupt being serviced; further irqs held pending
//  irq_ack        out  1   1-cycle pulse on acceptance
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state RUN; epc=0; in_handler=0; irq_ack=0; pending=0; guard=0; synchronizer cleared.
//   - While rst_n=0, combinationally all *_rst=1, all *_en=0, pc_override=0.
//  Request capture:
//   - irq passes SYNC_STAGES flops; rising edge of synced irq sets pending.
//   - pending stays set until accepted; irq edges while pending are merged.
//  States: RUN (in_handler=0), HANDLER (in_handler=1). Per cycle, priority top-down:
//   1. ERET: HANDLER & id_valid & is_eret_id.
//      - pc_override=1, addr=epc; id_rst=1; exe_rst=1; IF/MEM/WB enabled.
//      - Next state RUN; guard<=GUARD_CYCLES. Takes priority over reg_stall.
//      - ERET in RUN: treated as NOP, normal flow.
//   2. ACCEPT: RUN & pending & int_en & guard==0 & id_valid & !reg_stall & !is_branch_exe.
//      - epc<=inst_addr_id; pc_override=1, addr=HANDLER_ADDR; id_rst=1; exe_rst=1; IF/MEM/WB enabled.
//      - irq_ack=1; pending<=0; next state HANDLER. EXE/MEM/WB contents complete normally.
//   3. STALL: reg_stall.
//      - if_en=0, id_en=0 (hold); exe_rst=1 (bubble); mem_en=wb_en=1.
//   4. NORMAL: all *_en=1, all *_rst=0.
//  guard: decrements to 0 each cycle in RUN, saturating at 0.
//  Acceptance deferral: delay slot in ID (is_branch_exe) or bubble (!id_valid) defers; re-evaluated every cycle.
//  irq arriving in HANDLER sets pending; taken after ERET + guard.
//  int_en=0: pending held, never dropped.
//  Latency: synced irq edge to irq_ack >= SYNC_STAGES+1 cycles.
//  Handler first fetch: cycle after irq_ack.
//  Outputs epc, in_handler, irq_ack are registered; stage controls and pc_override are combinational from state/inputs.
// STRUCTURE
//  - State encodings local to this module.
//  - ERET opcode/funct and default HANDLER_ADDR live in mips_define.vh.
//  - One sub-module: irq_sync (SYNC_STAGES synchronizer + rising-edge detector, 1-cycle pulse out).
// TESTING
//  1. Reset: rst_n=0 two cycles -> all *_rst=1, *_en=0, epc=0, in_handler=0;
//     release -> all *_en=1 next cycle.
//  2. Load-use: reg_stall=1 one cycle -> if_en=id_en=0, exe_rst=1, mem_en=wb_en=1;
//     next cycle all enables 1.
//  3. Accept: irq rises, int_en=1, id_valid=1, inst_addr_id=0x0000_0040
//     -> irq_ack at cycle 3 after edge; epc=0x40; pc_override=1/addr=0x100; id_rst=exe_rst=1.
//  4. Delay slot: irq pending with is_branch_exe=1 -> no ack that cycle;
//     ack next cycle with epc=branch target PC in ID.
//  5. ERET: in HANDLER, is_eret_id=1, id_valid=1 -> pc_override addr=0x40, in_handler=0;
//     second irq edge 1 cycle later -> ack no earlier than 3 cycles after ERET.
//  6. Reset mid-handler: rst_n=0 while in_handler=1 -> in_handler=0, pending=0, epc=0;
//     ERET afterwards is a NOP.

Source files
------------

// File: rtl/pipe_int_ctrl_pkg.sv
// Shared types and defaults for the pipeline interrupt sequencer: the per-stage
// enable/flush bundle and the reset-time and free-running control patterns.
package pipe_int_ctrl_pkg;

  localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_0100;
  localparam int          DEF_SYNC_STAGES  = 2;
  localparam int          DEF_GUARD_CYCLES = 3;

  typedef struct packed {
    logic en_if;
    logic en_id;
    logic en_exe;
    logic en_mem;
    logic en_wb;
    logic rst_if;
    logic rst_id;
    logic rst_exe;
    logic rst_mem;
    logic rst_wb;
  } stage_ctrl_t;

  // Held in reset: every stage flushed and frozen.
  function automatic stage_ctrl_t ctrl_idle();
    stage_ctrl_t c;
    c = '{en_if: 1'b0, en_id: 1'b0, en_exe: 1'b0, en_mem: 1'b0, en_wb: 1'b0,
          rst_if: 1'b1, rst_id: 1'b1, rst_exe: 1'b1, rst_mem: 1'b1, rst_wb: 1'b1};
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_run();
    stage_ctrl_t c;
    c = '{en_if: 1'b1, en_id: 1'b1, en_exe: 1'b1, en_mem: 1'b1, en_wb: 1'b1,
          rst_if: 1'b0, rst_id: 1'b0, rst_exe: 1'b0, rst_mem: 1'b0, rst_wb: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/pipe_int_ctrl_irq_sync.sv
// Brings the asynchronous irq line into the clk domain through SYNC_STAGES flops
// and emits a one-cycle pulse on each rising edge of the synchronized level.
module pipe_int_ctrl_irq_sync
  import pipe_int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic irq_rise
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p  <= '0;
      level_p <= 1'b0;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], irq};
      level_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign irq_rise = sync_p[SYNC_STAGES-1] & ~level_p;

endmodule

// File: rtl/pipe_int_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS datapath: stage enables/flushes,
// load-use bubbles, single-level external interrupt entry and ERET return.
module pipe_int_ctrl
  import pipe_int_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
  parameter int          SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int          GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq,
  input  logic        int_en,
  input  logic        reg_stall,
  input  logic        id_valid,
  input  logic        is_branch_exe,
  input  logic        is_eret_id,
  input  logic [31:0] inst_addr_id,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        pc_override,
  output logic [31:0] pc_override_addr,
  output logic [31:0] epc,
  output logic        in_handler,
  output logic        irq_ack
);

  typedef enum logic {ST_RUN, ST_HANDLER} state_t;

  localparam int            GW         = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

  state_t      state;
  logic        pending;
  logic [GW-1:0] guard;
  logic        irq_rise;
  logic        eret_take;
  logic        accept;
  stage_ctrl_t ctrl;

  pipe_int_ctrl_irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .irq_rise (irq_rise)
  );

  assign eret_take = (state == ST_HANDLER) & id_valid & is_eret_id;

  // A delay slot or a bubble in ID has no restartable PC, so entry waits for them.
  assign accept = (state == ST_RUN) & pending & int_en & (guard == '0) &
                  id_valid & ~reg_stall & ~is_branch_exe;

  always_comb begin
    ctrl             = ctrl_run();
    pc_override      = 1'b0;
    pc_override_addr = epc;
    if (!rst_n) begin
      ctrl = ctrl_idle();
    end else if (eret_take) begin
      ctrl.rst_id  = 1'b1;
      ctrl.rst_exe = 1'b1;
      pc_override  = 1'b1;
    end else if (accept) begin
      ctrl.rst_id      = 1'b1;
      ctrl.rst_exe     = 1'b1;
      pc_override      = 1'b1;
      pc_override_addr = HANDLER_ADDR;
    end else if (reg_stall) begin
      ctrl.en_if   = 1'b0;
      ctrl.en_id   = 1'b0;
      ctrl.rst_exe = 1'b1;
    end
  end

  assign if_en   = ctrl.en_if;
  assign id_en   = ctrl.en_id;
  assign exe_en  = ctrl.en_exe;
  assign mem_en  = ctrl.en_mem;
  assign wb_en   = ctrl.en_wb;
  assign if_rst  = ctrl.rst_if;
  assign id_rst  = ctrl.rst_id;
  assign exe_rst = ctrl.rst_exe;
  assign mem_rst = ctrl.rst_mem;
  assign wb_rst  = ctrl.rst_wb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      epc        <= '0;
      in_handler <= 1'b0;
      irq_ack    <= 1'b0;
      pending    <= 1'b0;
      guard      <= '0;
    end else begin
      irq_ack <= accept;
      // A new edge landing in the acceptance cycle survives as the next request.
      pending <= irq_rise | (pending & ~accept);
      if (eret_take) begin
        state      <= ST_RUN;
        in_handler <= 1'b0;
        guard      <= GUARD_LOAD;
      end else if (accept) begin
        state      <= ST_HANDLER;
        in_handler <= 1'b1;
        epc        <= inst_addr_id;
      end else if ((state == ST_RUN) && (guard != '0)) begin
        guard <= guard - GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Directed bench for pipe_int_ctrl: an abstract per-cycle model checked on every
// negedge, plus hand-computed checkpoints for reset, stall, entry, ERET and guard.
module tb_pipe_int_ctrl;

  localparam int          S = 2;
  localparam int          G = 3;
  localparam logic [31:0] H = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, irq, int_en, reg_stall, id_valid, is_branch_exe, is_eret_id;
  logic [31:0] inst_addr_id;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        pc_override, in_handler, irq_ack;
  logic [31:0] pc_override_addr, epc;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_int_ctrl #(.HANDLER_ADDR(H), .SYNC_STAGES(S), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .int_en(int_en), .reg_stall(reg_stall),
    .id_valid(id_valid), .is_branch_exe(is_branch_exe), .is_eret_id(is_eret_id),
    .inst_addr_id(inst_addr_id),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .pc_override(pc_override), .pc_override_addr(pc_override_addr),
    .epc(epc), .in_handler(in_handler), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Abstract model: irq history, request flag, mode, saved PC, guard countdown.
  bit          hist [S+1];
  bit          m_pending, m_handler, m_ack;
  logic [31:0] m_epc;
  int          m_guard;
  bit          m_take_eret, m_take_irq, m_edge;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      m_pending = 0; m_handler = 0; m_ack = 0; m_epc = '0; m_guard = 0;
    end else begin
      m_take_eret = m_handler && id_valid && is_eret_id;
      m_take_irq  = !m_handler && m_pending && int_en && (m_guard == 0) &&
                    id_valid && !reg_stall && !is_branch_exe;
      m_edge      = hist[S-1] && !hist[S];
      m_ack       = m_take_irq;
      m_pending   = m_edge || (m_pending && !m_take_irq);
      if (m_take_eret) m_guard = G;
      else if (!m_handler && m_guard > 0) m_guard = m_guard - 1;
      if (m_take_irq) begin
        m_epc     = inst_addr_id;
        m_handler = 1;
      end
      if (m_take_eret) m_handler = 0;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = irq;
    end
  end

  logic [4:0]  e_en, e_rst, en_mask;
  logic        e_ovr;
  logic [31:0] e_addr;

  always @(negedge clk) begin
    en_mask = 5'b11111;
    e_en    = 5'b11111;
    e_rst   = 5'b00000;
    e_ovr   = 1'b0;
    e_addr  = '0;
    if (!rst_n) begin
      e_en  = 5'b00000;
      e_rst = 5'b11111;
    end else if (m_handler && id_valid && is_eret_id) begin
      en_mask = 5'b10011;
      e_rst   = 5'b01100;
      e_ovr   = 1'b1;
      e_addr  = m_epc;
    end else if (!m_handler && m_pending && int_en && m_guard == 0 && id_valid &&
                 !reg_stall && !is_branch_exe) begin
      en_mask = 5'b10011;
      e_rst   = 5'b01100;
      e_ovr   = 1'b1;
      e_addr  = H;
    end else if (reg_stall) begin
      en_mask = 5'b11011;
      e_en    = 5'b00011;
      e_rst   = 5'b00100;
    end
    chk5("model_en", {if_en, id_en, exe_en, mem_en, wb_en} & en_mask, e_en & en_mask);
    chk5("model_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, e_rst);
    chk1("model_pc_override", pc_override, e_ovr);
    if (e_ovr) chk32("model_pc_override_addr", pc_override_addr, e_addr);
    chk32("model_epc", epc, m_epc);
    chk1("model_in_handler", in_handler, m_handler);
    chk1("model_irq_ack", irq_ack, m_ack);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; irq = 0; int_en = 1; reg_stall = 0; id_valid = 1;
    is_branch_exe = 0; is_eret_id = 0; inst_addr_id = 32'h40;

    // Reset held two cycles
    tick(); tick();
    @(negedge clk);
    chk1("reset_if_rst", if_rst, 1'b1);
    chk1("reset_wb_rst", wb_rst, 1'b1);
    chk1("reset_if_en", if_en, 1'b0);
    chk1("reset_mem_en", mem_en, 1'b0);
    chk32("reset_epc", epc, 32'h0);
    chk1("reset_in_handler", in_handler, 1'b0);
    tick(); rst_n = 1;
    @(negedge clk);
    chk1("release_if_en", if_en, 1'b1);
    chk1("release_wb_en", wb_en, 1'b1);
    chk1("release_exe_rst", exe_rst, 1'b0);

    // Load-use bubble
    tick(); reg_stall = 1;
    @(negedge clk);
    chk1("stall_if_en", if_en, 1'b0);
    chk1("stall_id_en", id_en, 1'b0);
    chk1("stall_exe_rst", exe_rst, 1'b1);
    chk1("stall_mem_en", mem_en, 1'b1);
    chk1("stall_wb_en", wb_en, 1'b1);
    tick(); reg_stall = 0;
    @(negedge clk);
    chk1("unstall_if_en", if_en, 1'b1);
    chk1("unstall_id_en", id_en, 1'b1);

    // Interrupt entry: ack on the third edge after irq is first sampled
    tick(); irq = 1;
    @(posedge clk); @(negedge clk);
    chk1("acc_e0_ack", irq_ack, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("acc_e1_ack", irq_ack, 1'b0);
    chk1("acc_e1_ovr", pc_override, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("acc_ovr", pc_override, 1'b1);
    chk32("acc_addr", pc_override_addr, 32'h100);
    chk1("acc_id_rst", id_rst, 1'b1);
    chk1("acc_exe_rst", exe_rst, 1'b1);
    @(posedge clk); #1; irq = 0; inst_addr_id = 32'h44;
    @(negedge clk);
    chk1("acc_ack", irq_ack, 1'b1);
    chk32("acc_epc", epc, 32'h40);
    chk1("acc_in_handler", in_handler, 1'b1);

    // Second request raised inside the handler stays pending
    tick(); tick(); tick();
    irq = 1;
    repeat (4) tick();
    @(negedge clk);
    chk1("hold_in_handler", in_handler, 1'b1);
    chk1("hold_ack", irq_ack, 1'b0);
    tick(); is_eret_id = 1; inst_addr_id = 32'h60;
    @(negedge clk);
    chk1("eret_ovr", pc_override, 1'b1);
    chk32("eret_addr", pc_override_addr, 32'h40);
    chk1("eret_id_rst", id_rst, 1'b1);
    tick(); is_eret_id = 0; inst_addr_id = 32'h80;
    @(negedge clk);
    chk1("eret_in_handler", in_handler, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      chk1("guard_ack", irq_ack, 1'b0);
      chk1("guard_ovr", pc_override, k == 3);
    end
    tick();
    @(negedge clk);
    chk1("guard_done_ack", irq_ack, 1'b1);
    chk32("guard_done_epc", epc, 32'h80);

    // Return again, then defer entry across a delay slot, a bubble and int_en=0
    tick(); irq = 0; is_eret_id = 1;
    tick(); is_eret_id = 0;
    @(negedge clk);
    chk1("eret2_in_handler", in_handler, 1'b0);
    repeat (5) tick();
    is_branch_exe = 1; inst_addr_id = 32'h200; irq = 1;
    repeat (3) tick();
    @(negedge clk);
    chk1("slot_ovr", pc_override, 1'b0);
    chk1("slot_ack", irq_ack, 1'b0);
    tick(); is_branch_exe = 0; id_valid = 0;
    @(negedge clk);
    chk1("bubble_ovr", pc_override, 1'b0);
    tick(); id_valid = 1; int_en = 0;
    @(negedge clk);
    chk1("inten_off_ovr", pc_override, 1'b0);
    tick(); int_en = 1; inst_addr_id = 32'hA0;
    @(negedge clk);
    chk1("deferred_ovr", pc_override, 1'b1);
    chk32("deferred_addr", pc_override_addr, 32'h100);
    tick();
    @(negedge clk);
    chk1("deferred_ack", irq_ack, 1'b1);
    chk32("deferred_epc", epc, 32'hA0);

    // Reset mid-handler, then ERET must be a no-op
    tick(); irq = 0;
    repeat (3) tick();
    rst_n = 0;
    tick();
    @(negedge clk);
    chk1("midrst_in_handler", in_handler, 1'b0);
    chk32("midrst_epc", epc, 32'h0);
    tick(); rst_n = 1; is_eret_id = 1;
    @(negedge clk);
    chk1("nop_eret_ovr", pc_override, 1'b0);
    chk1("nop_eret_id_rst", id_rst, 1'b0);
    tick(); is_eret_id = 0;
    repeat (4) tick();
    @(negedge clk);
    chk1("post_rst_ack", irq_ack, 1'b0);
    chk1("post_rst_in_handler", in_handler, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
